// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display path.
// Holds the BCD digit format, the converter FSM states and the overflow-limit helper.
package calc_disp_pkg;

  localparam int         BCD_W     = 4;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Elaboration-time helper: 10**n, used to size the overflow limit.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added,
// so the following left shift carries correctly into the next digit.
module bcd_add3
  import calc_disp_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/busy/valid handshake, feeding the 7-segment display path.
//
//   state | meaning
//   IDLE  | waiting for start; bcd_out/ovf hold the last result
//   SHIFT | one add-3 + shift per cycle, BIN_W cycles
//   DONE  | publish scratch (or blank code on overflow), pulse valid
module bin_to_bcd_seq
  import calc_disp_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      valid,
  output logic                      ovf,
  output logic [BCD_W*DIGITS-1:0]   bcd_out
);

  localparam int              SCR_W = BCD_W * DIGITS;
  localparam int              CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = pow10(DIGITS) - 1;

  state_t                   state, state_nxt;
  logic [BIN_W-1:0]         shift_reg;
  logic [SCR_W-1:0]         scratch;
  logic [SCR_W-1:0]         adjusted;
  logic [SCR_W+BIN_W-1:0]   shifted;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_pending;
  logic                     ovf_in;

  assign ovf_in  = 64'(bin_in) > LIMIT;
  assign busy    = (state != IDLE);

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch [i*BCD_W +: BCD_W]),
      .q (adjusted[i*BCD_W +: BCD_W])
    );
  end

  // Bits pushed out of the top digit are dropped; only reachable on overflow.
  assign shifted = {adjusted, shift_reg} << 1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      valid       <= 1'b0;
      ovf         <= 1'b0;
      bcd_out     <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift_reg   <= bin_in;
            scratch     <= '0;
            cnt         <= CNT_W'(BIN_W);
            ovf_pending <= ovf_in;
          end
        end
        SHIFT: begin
          shift_reg <= shifted[BIN_W-1:0];
          scratch   <= shifted[SCR_W+BIN_W-1:BIN_W];
          cnt       <= cnt - CNT_W'(1);
        end
        DONE: begin
          valid <= 1'b1;
          if (ovf_pending) begin
            bcd_out <= {DIGITS{BCD_BLANK}};
            ovf     <= 1'b1;
          end else begin
            bcd_out <= scratch;
            ovf     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
